// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bus for the bit serializer: parallel handshake, stream
// controls and the serial output side.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             flush;
  logic             en;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             last_bit;
  logic             busy;

  // Source / controller side
  modport master (
    output flush, en, in_data, in_valid,
    input  in_ready, ser_bit, ser_valid, last_bit, busy
  );

  // Serializer side
  modport slave (
    input  flush, en, in_data, in_valid,
    output in_ready, ser_bit, ser_valid, last_bit, busy
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that a
// continuously fed stream has no idle bit between consecutive words.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_bit_serializer_if.slave  io_bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_shift, w_shift_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [WIDTH-1:0]  r_hold, w_hold_d;
  logic              r_hold_full, w_hold_full_d;

  logic              w_accept;
  logic              w_end_of_word;
  logic [WIDTH-1:0]  w_shifted;

  // Handshake and shift helpers
  always_comb begin
    io_bus.in_ready = !r_hold_full && !io_bus.flush;
    w_accept        = io_bus.in_valid && io_bus.in_ready;
    w_end_of_word   = (r_state == StShift) && io_bus.en && (r_cnt == LastCnt);
    if (MSB_FIRST) begin
      w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    end
  end

  // Next-state logic for state, shifter, counter and holding register
  always_comb begin
    w_state_d     = r_state;
    w_shift_d     = r_shift;
    w_cnt_d       = r_cnt;
    w_hold_d      = r_hold;
    w_hold_full_d = r_hold_full;

    if (io_bus.flush) begin
      w_state_d     = StIdle;
      w_shift_d     = '0;
      w_cnt_d       = '0;
      w_hold_full_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            w_shift_d = io_bus.in_data;
            w_cnt_d   = '0;
            w_state_d = StShift;
          end
        end
        StShift: begin
          if (w_end_of_word) begin
            if (r_hold_full) begin
              w_shift_d     = r_hold;
              w_cnt_d       = '0;
              w_hold_full_d = 1'b0;
            end else if (w_accept) begin
              // Bypass the holding register to avoid a one-bit gap
              w_shift_d = io_bus.in_data;
              w_cnt_d   = '0;
            end else begin
              // Clear the shifter so ser_bit reads 0 while idle
              w_state_d = StIdle;
              w_shift_d = '0;
              w_cnt_d   = '0;
            end
          end else begin
            if (io_bus.en) begin
              w_shift_d = w_shifted;
              w_cnt_d   = r_cnt + 1'b1;
            end
            // in_ready is low while hold is full, so this never overwrites it
            if (w_accept) begin
              w_hold_d      = io_bus.in_data;
              w_hold_full_d = 1'b1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_shift     <= w_shift_d;
      r_cnt       <= w_cnt_d;
      r_hold      <= w_hold_d;
      r_hold_full <= w_hold_full_d;
    end
  end

  // Serial outputs decoded straight from the registers
  always_comb begin
    io_bus.ser_valid = (r_state == StShift);
    io_bus.ser_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    io_bus.last_bit  = (r_state == StShift) && (r_cnt == LastCnt);
    io_bus.busy      = (r_state == StShift) || r_hold_full;
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for the bit serializer: scoreboard of expected serial bits driven by
// accepted words, checked by a negedge monitor; plus a small LSB-first DUT.
module tb_seq_bit_serializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   en_mode = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(W)) a ();
  seq_bit_serializer_if #(.WIDTH(4)) b ();

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(a)
  );

  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
    .clk   (clk),
    .rst_n (rst2_n),
    .io_bus(b)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: a queue of the bits the stream still owes, in order
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      automatic int sz = exp_q.size();
      chk("busy", 32'(a.busy), 32'(sz != 0));
      chk("in_ready", 32'(a.in_ready), 32'(!a.flush && sz <= W));
      if (sz == 0) begin
        chk("ser_valid_idle", 32'(a.ser_valid), 32'd0);
        chk("ser_bit_idle", 32'(a.ser_bit), 32'd0);
        chk("last_bit_idle", 32'(a.last_bit), 32'd0);
      end else begin
        chk("ser_valid", 32'(a.ser_valid), 32'd1);
        chk("ser_bit", 32'(a.ser_bit), 32'(exp_q[0].b));
        chk("last_bit", 32'(a.last_bit), 32'(exp_q[0].last));
      end
      if (a.flush) begin
        exp_q.delete();
      end else begin
        if (sz != 0 && a.en) void'(exp_q.pop_front());
        if (a.in_valid && a.in_ready) begin
          for (int i = 0; i < W; i++) begin
            exp_t e;
            e.b    = a.in_data[W-1-i];
            e.last = (i == W - 1);
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // Bit-rate enable generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (en_mode)
        0:       a.en = 1'b1;
        1:       a.en = (cyc % 3 == 0);
        default: a.en = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [W-1:0] w);
    int  t = 0;
    logic acc = 1'b0;
    a.in_data  = w;
    a.in_valid = 1'b1;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = a.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    a.in_valid = 1'b0;
    if (!acc) fail_now("send_accept");
  endtask

  task automatic wait_idle();
    int t = 0;
    while (a.busy && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (a.busy) fail_now("wait_idle");
  endtask

  task automatic flush_pulse();
    a.flush = 1'b1;
    @(posedge clk);
    #1;
    a.flush = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] e4;
    a.flush = 1'b0; a.en = 1'b0; a.in_data = '0; a.in_valid = 1'b0;
    b.flush = 1'b0; b.en = 1'b1; b.in_data = '0; b.in_valid = 1'b0;
    #1;
    chk("rst_ser_valid", 32'(a.ser_valid), 32'd0);
    chk("rst_ser_bit", 32'(a.ser_bit), 32'd0);
    chk("rst_last_bit", 32'(a.last_bit), 32'd0);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_in_ready", 32'(a.in_ready), 32'd1);
    idle_cycles(3);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    idle_cycles(2);

    // LSB-first, WIDTH=4: 4'b1101 -> 1,0,1,1
    e4 = 4'b1101;
    b.in_data  = e4;
    b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w4_valid", 32'(b.ser_valid), 32'd1);
      chk("w4_bit", 32'(b.ser_bit), 32'(e4[i]));
      chk("w4_last", 32'(b.last_bit), 32'(i == 3));
    end
    @(negedge clk);
    chk("w4_done_valid", 32'(b.ser_valid), 32'd0);
    chk("w4_done_busy", 32'(b.busy), 32'd0);

    // Asynchronous reset mid-word
    @(posedge clk);
    #1;
    b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("w4_mid_valid", 32'(b.ser_valid), 32'd1);
    rst2_n = 1'b0;
    #1;
    chk("w4_arst_valid", 32'(b.ser_valid), 32'd0);
    chk("w4_arst_busy", 32'(b.busy), 32'd0);
    chk("w4_arst_ready", 32'(b.in_ready), 32'd1);
    idle_cycles(2);
    rst2_n = 1'b1;

    // Single word, full rate
    en_mode = 0;
    idle_cycles(1);
    send(8'h0B);
    wait_idle();
    idle_cycles(2);

    // Back-to-back words, then a third pending behind a full hold register
    send(8'hB0);
    send(8'h0B);
    wait_idle();
    send(8'h3C);
    send(8'hC3);
    send(8'h96);
    wait_idle();

    // Throttled stream, one bit every third cycle
    en_mode = 1;
    send(8'hA5);
    wait_idle();

    // Flush mid-word with the hold register full
    en_mode = 0;
    idle_cycles(1);
    send(8'h5A);
    send(8'h81);
    idle_cycles(2);
    flush_pulse();
    send(8'hFF);
    wait_idle();

    // Random traffic, random enable, occasional flush
    en_mode = 2;
    for (int n = 0; n < 80; n++) begin
      idle_cycles($urandom_range(0, 2) == 0 ? $urandom_range(1, 12) : 0);
      if ($urandom_range(0, 14) == 0) flush_pulse();
      send(W'($urandom));
    end
    wait_idle();
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
